// File: rtl/prefetch_fetch_pkg.sv
// Shared types for the prefetching IF stage: redirect selectors, CSR views and
// the 65-bit fetch entry carried through the response buffer.
package prefetch_fetch_pkg;

   typedef enum logic [1:0] {
      PC_BRANCH = 2'd0,
      PC_MEPC   = 2'd1,
      PC_TRAP   = 2'd2
   } pc_sel_t;

   typedef enum logic [1:0] {
      MTVEC_DIRECT   = 2'd0,
      MTVEC_VECTORED = 2'd1
   } mtvec_mode_t;

   typedef struct packed {
      logic [29:0] base;
      mtvec_mode_t mode;
   } mtvec_t;

   typedef struct packed {
      logic        irq;
      logic [30:0] code;
   } mcause_t;

   localparam int FETCH_ENTRY_W = 65;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        err;
   } fetch_entry_t;

   // Only interrupts are vectored; synchronous traps always land on the base.
   function automatic logic [31:0] trap_target(input mtvec_t tv, input mcause_t mc);
      logic [31:0] t;
      t = {tv.base, 2'b00};
      if (tv.mode == MTVEC_VECTORED && mc.irq)
         t = t + (32'(mc.code) << 2);
      return t;
   endfunction

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bus bundle, read-only usage by the fetch unit.
interface wishbone_if;
   logic        cyc;
   logic        stb;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic        we;
   logic        ack;
   logic        err;
   logic        stall;
   logic [31:0] rdata;

   modport MASTER (output cyc, stb, adr, sel, we, input ack, err, stall, rdata);
   modport SLAVE  (input cyc, stb, adr, sel, we, output ack, err, stall, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; used as the response buffer and the in-flight
// PC queue. Push while full is accepted only when a pop frees a slot the same cycle.
module fetch_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);
   assign w_pop   = pop_i && !empty_o;
   assign w_push  = push_i && (!full_o || w_pop);
   assign data_o  = r_mem[r_rd];
   assign count_o = r_count;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= nxt(r_wr);
         if (w_pop)  r_rd <= nxt(r_rd);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) r_mem[r_wr] <= data_i;
   end

endmodule

// File: rtl/prefetch_fetch.sv
// Prefetching IF stage: pipelined Wishbone reads with credit-based issue,
// response FIFO, stale-response discard on redirect, and the IF/ID register.
module prefetch_fetch
   import prefetch_fetch_pkg::*;
#(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   wishbone_if.MASTER  wb_if,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        fetch_err_o,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        new_pc_en_i,
   input  pc_sel_t     pc_sel_i,
   input  logic [31:0] branch_target_i,
   input  logic [31:0] csr_mepc_i,
   input  mtvec_t      mtvec_i,
   input  mcause_t     mcause_i
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
   localparam logic [OW-1:0] MAX_L   = OW'(MAX_OUTSTANDING);

   logic [31:0]   r_fetch_pc;
   logic [OW-1:0] r_outstanding;
   logic [OW-1:0] r_discard;
   logic          r_valid;
   logic [31:0]   r_instr;
   logic [31:0]   r_pc;
   logic          r_err;

   logic [31:0]   w_target;
   logic [CW:0]   w_inflight;
   logic          w_stb;
   logic          w_accept;
   logic          w_resp;
   logic          w_keep;
   logic          w_load;
   logic          w_head_vld;
   logic          w_push;
   logic          w_pop;
   fetch_entry_t  w_resp_entry;
   fetch_entry_t  w_fifo_head;
   fetch_entry_t  w_head;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic [CW-1:0] w_count;
   logic [31:0]   w_pcq_head;
   logic          w_pcq_full;
   logic          w_pcq_empty;
   logic [OW-1:0] w_pcq_count;

   always_comb begin
      w_target = branch_target_i;
      case (pc_sel_i)
         PC_BRANCH: w_target = branch_target_i;
         PC_MEPC:   w_target = csr_mepc_i;
         PC_TRAP:   w_target = trap_target(mtvec_i, mcause_i);
         default:   w_target = branch_target_i;
      endcase
   end

   // Credit rule: every issued read already owns a FIFO slot, so pushes never overflow.
   assign w_inflight = (CW + 1)'(w_count) + (CW + 1)'(r_outstanding);
   assign w_stb      = !rst_i && !new_pc_en_i && (w_inflight < DEPTH_L) &&
                       (r_outstanding < MAX_L);
   assign w_accept   = w_stb && !wb_if.stall;
   assign w_resp     = !rst_i && (r_outstanding != '0) && (wb_if.ack || wb_if.err);
   assign w_keep     = w_resp && (r_discard == '0) && !new_pc_en_i;

   assign wb_if.cyc = !rst_i && (w_stb || (r_outstanding != '0));
   assign wb_if.stb = w_stb;
   assign wb_if.adr = r_fetch_pc;
   assign wb_if.sel = 4'hF;
   assign wb_if.we  = 1'b0;

   assign w_resp_entry = '{instr: wb_if.rdata, pc: w_pcq_head, err: wb_if.err};

   // An empty FIFO lets a fresh response go straight into IF/ID.
   assign w_load     = !new_pc_en_i && !flush_i && !stall_i;
   assign w_head_vld = !w_fifo_empty || w_keep;
   assign w_head     = w_fifo_empty ? w_resp_entry : w_fifo_head;
   assign w_pop      = w_load && !w_fifo_empty;
   assign w_push     = w_keep && !(w_load && w_fifo_empty);

   fetch_fifo #(.WIDTH(FETCH_ENTRY_W), .DEPTH(DEPTH)) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (new_pc_en_i),
      .push_i  (w_push),
      .data_i  (w_resp_entry),
      .pop_i   (w_pop),
      .data_o  (w_fifo_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .count_o (w_count)
   );

   // Tracks the PC of every read on the bus, stale ones included, so it
   // stays aligned with the response order across redirects.
   fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (1'b0),
      .push_i  (w_accept),
      .data_i  (r_fetch_pc),
      .pop_i   (w_resp),
      .data_o  (w_pcq_head),
      .full_o  (w_pcq_full),
      .empty_o (w_pcq_empty),
      .count_o (w_pcq_count)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         if (new_pc_en_i)   r_fetch_pc <= w_target;
         else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;

         case ({w_accept, w_resp})
            2'b10:   r_outstanding <= r_outstanding + OW'(1);
            2'b01:   r_outstanding <= r_outstanding - OW'(1);
            default: ;
         endcase

         if (new_pc_en_i)
            r_discard <= r_outstanding - OW'(w_resp);
         else if (w_resp && r_discard != '0)
            r_discard <= r_discard - OW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
         r_err   <= 1'b0;
      end else if (new_pc_en_i || flush_i) begin
         r_valid <= 1'b0;
      end else if (!stall_i) begin
         r_valid <= w_head_vld;
         if (w_head_vld) begin
            r_instr <= w_head.instr;
            r_pc    <= w_head.pc;
            r_err   <= w_head.err;
         end
      end
   end

   assign valid_o     = r_valid;
   assign instr_o     = r_instr;
   assign pc_o        = r_pc;
   assign fetch_err_o = r_err;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         a_count:    assert (w_count <= DEPTH_C);
         a_out:      assert (r_outstanding <= MAX_L);
         a_discard:  assert (r_discard <= r_outstanding);
         a_pcq:      assert (w_pcq_count == r_outstanding);
         a_no_ovf:   assert (!(w_push && w_fifo_full && !w_pop));
         a_pcq_ovf:  assert (!(w_accept && w_pcq_full));
         a_pcq_udf:  assert (!(w_resp && w_pcq_empty));
      end
   end

endmodule

// File: tb/tb_prefetch_fetch.sv
// Scoreboard bench: accepted bus reads push expected IF/ID entries, consumed
// IF/ID outputs pop and compare; a pipelined slave model with variable latency.
module tb_prefetch_fetch;
   import prefetch_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] adr;
      int          due;
   } sreq_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_o, fetch_err_o;
   logic [31:0] instr_o, pc_o;
   logic        stall_i, flush_i, new_pc_en;
   pc_sel_t     pc_sel;
   logic [31:0] branch_target, csr_mepc;
   mtvec_t      mtvec;
   mcause_t     mcause;

   wishbone_if wb();

   prefetch_fetch #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RST_PC)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .wb_if           (wb),
      .valid_o         (valid_o),
      .instr_o         (instr_o),
      .pc_o            (pc_o),
      .fetch_err_o     (fetch_err_o),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .new_pc_en_i     (new_pc_en),
      .pc_sel_i        (pc_sel),
      .branch_target_i (branch_target),
      .csr_mepc_i      (csr_mepc),
      .mtvec_i         (mtvec),
      .mcause_i        (mcause)
   );

   always #5 clk = ~clk;

   sreq_t        sq[$];
   fetch_entry_t sb[$];
   int           n_chk = 0, n_fail = 0, cyc_n = 0, lat = 1, n_errs = 0;
   logic [31:0]  err_adr = 32'h8;
   logic [31:0]  m_next, exp_target;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Slave: ack/err `lat` cycles after accept, one response per cycle; cyc low aborts.
   initial begin
      sreq_t r;
      wb.ack = 1'b0; wb.err = 1'b0; wb.rdata = '0;
      forever begin
         @(posedge clk); #1;
         cyc_n++;
         wb.ack = 1'b0; wb.err = 1'b0; wb.rdata = '0;
         if (sq.size() != 0 && sq[0].due <= cyc_n) begin
            if (sq[0].adr == err_adr) wb.err = 1'b1;
            else                      wb.ack = 1'b1;
            wb.rdata = word_of(sq[0].adr);
         end
         @(negedge clk);
         if (!wb.cyc) sq.delete();
         else begin
            if (wb.ack || wb.err) void'(sq.pop_front());
            if (wb.stb && !wb.stall) begin
               r.adr = wb.adr;
               r.due = cyc_n + lat;
               sq.push_back(r);
            end
         end
      end
   end

   // Monitor: expected stream built from the bench's own next-PC model.
   initial begin
      fetch_entry_t e;
      logic         prev_hold;
      logic [31:0]  prev_adr;
      prev_hold = 1'b0; prev_adr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            m_next    = RST_PC;
            prev_hold = 1'b0;
         end else if (new_pc_en) begin
            chk("redir_stb", wb.stb, 0);
            sb.delete();
            m_next    = exp_target;
            prev_hold = 1'b0;
         end else begin
            if (valid_o && (flush_i || !stall_i)) begin
               chk("sb_nonempty", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  if (!flush_i) begin
                     chk("pc", pc_o, e.pc);
                     chk("instr", instr_o, e.instr);
                     chk("ferr", fetch_err_o, e.err);
                     if (fetch_err_o) n_errs++;
                  end
               end
            end
            if (prev_hold && wb.stb) chk("adr_hold", wb.adr, prev_adr);
            if (wb.stb && !wb.stall) begin
               chk("adr_seq", wb.adr, m_next);
               sb.push_back('{instr: word_of(m_next), pc: m_next, err: (m_next == err_adr)});
               m_next = m_next + 32'd4;
            end
            prev_hold = wb.stb && wb.stall;
            prev_adr  = wb.adr;
         end
      end
   end

   task automatic do_redirect(input pc_sel_t sel, input logic [31:0] tgt, input bit on_ack);
      int n;
      n = 0;
      if (on_ack) begin
         do begin
            @(posedge clk); #2;
            n++;
         end while (!wb.ack && n < 50);
         chk("ack_wait", n < 50, 1);
      end else begin
         @(posedge clk); #1;
      end
      new_pc_en  = 1'b1;
      pc_sel     = sel;
      exp_target = tgt;
      @(posedge clk); #1;
      new_pc_en  = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!valid_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, valid_o, 1);
   endtask

   initial begin
      int k;
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_en = 1'b0;
      pc_sel = PC_BRANCH; branch_target = '0; csr_mepc = '0;
      mtvec = '0; mcause = '0; exp_target = '0; wb.stall = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_ferr", fetch_err_o, 0);
      chk("rst_cyc", wb.cyc, 0);
      chk("rst_stb", wb.stb, 0);
      chk("rst_we", wb.we, 0);
      chk("rst_sel", wb.sel, 4'hF);

      // zero-wait stream from RESET_PC, error injected at 0x8
      tick(1); rst = 1'b0;
      wait_valid("first_valid");
      chk("first_pc", pc_o, RST_PC);
      repeat (12) begin
         @(negedge clk);
         chk("stream_vld", valid_o, 1);
      end
      tick(1); err_adr = 32'h1;

      // slave stall for 3 cycles
      wb.stall = 1'b1;
      tick(3); wb.stall = 1'b0;
      tick(8);

      // IF/ID stall: FIFO fills, issue stops, bus goes idle
      stall_i = 1'b1;
      tick(10);
      @(negedge clk);
      chk("fill_stb", wb.stb, 0);
      chk("fill_cyc", wb.cyc, 0);
      chk("fill_sb", sb.size(), 5);
      chk("fill_vld", valid_o, 1);
      tick(1); stall_i = 1'b0;
      tick(10);

      // flush drops only the IF/ID entry
      flush_i = 1'b1;
      tick(1); flush_i = 1'b0;
      @(negedge clk);
      chk("flush_vld", valid_o, 0);
      tick(6);

      // redirect latency with zero-wait slave
      branch_target = 32'h40;
      do_redirect(PC_BRANCH, 32'h40, 1'b0);
      k = 1;
      @(negedge clk);
      while (!valid_o && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("redir_lat", k, 3);
      chk("redir_pc", pc_o, 32'h40);
      tick(6);

      csr_mepc = 32'h200; branch_target = 32'h300;
      do_redirect(PC_MEPC, 32'h200, 1'b0);
      tick(8);

      mtvec = mtvec_t'(32'h1001); mcause = '{irq: 1'b1, code: 31'd7};
      do_redirect(PC_TRAP, 32'h101C, 1'b0);
      wait_valid("trapv_valid");
      chk("trapv_pc", pc_o, 32'h101C);
      tick(6);

      mtvec = mtvec_t'(32'h1000);
      do_redirect(PC_TRAP, 32'h1000, 1'b0);
      wait_valid("trapd_valid");
      chk("trapd_pc", pc_o, 32'h1000);
      tick(6);

      // fetch PC wraps past 0xFFFF_FFFC
      branch_target = 32'hFFFF_FFF8;
      do_redirect(PC_BRANCH, 32'hFFFF_FFF8, 1'b0);
      tick(12);

      // 4-cycle slave, branch taken in an ack cycle: stale words dropped
      lat = 4;
      tick(12);
      branch_target = 32'h100;
      do_redirect(PC_BRANCH, 32'h100, 1'b1);
      wait_valid("br_valid");
      chk("br_pc", pc_o, 32'h100);
      tick(20);

      // reset in the middle of a burst
      rst = 1'b1;
      tick(2);
      @(negedge clk);
      chk("mrst_vld", valid_o, 0);
      chk("mrst_cyc", wb.cyc, 0);
      tick(1); rst = 1'b0;
      wait_valid("mrst_valid");
      chk("mrst_pc", pc_o, RST_PC);
      tick(20);

      chk("err_seen", n_errs, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
